efpga_cfg_writer: RTL and testbench



---
 rtl/efpga_cfg_writer.sv | 196 +++++++++++++++++++
 tb/tb_efpga_cfg_writer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efpga_cfg_writer.sv
// efpga_cfg_writer: buffers 32-bit self-configuration writes, parses a frame
// header (0xA5 tag, row, frame count), packs data words into frames and hands
// each frame to the fabric with a valid/ready handshake.
// Optional CFG_CRC_EN: CRC-16-CCITT over all data words, checked against a
// trailer word after the last frame.
module efpga_cfg_writer #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int ROW_ADDR_W      = 5,
    parameter int FIFO_DEPTH      = 4,
    localparam int FRAME_BITS     = 32 * WORDS_PER_FRAME
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [31:0]           self_write_data_i,
    input  logic                  self_write_strobe_i,
    output logic                  cfg_busy_o,
    output logic                  cfg_done_o,
    output logic                  cfg_error_o,
    output logic [ROW_ADDR_W-1:0] frame_addr_o,
    output logic [FRAME_BITS-1:0] frame_data_o,
    output logic                  frame_strobe_o,
    input  logic                  frame_ready_i
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam int IW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, CHECK} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             mem_q [FIFO_DEPTH];
    logic [31:0]             mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [ROW_ADDR_W-1:0]   row_q, row_d;
    logic [7:0]              count_q, count_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    push, pop, empty, full;
    logic [31:0]             head;
`ifdef CFG_CRC_EN
    logic [15:0]             crc_q, crc_d;

    // CRC-16-CCITT, poly 0x1021, one 32-bit word shifted in MSB first
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[15] ^ w[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    assign empty          = (level_q == '0);
    assign full           = (level_q == LW'(FIFO_DEPTH));
    assign head           = mem_q[rd_ptr_q];
    assign cfg_busy_o     = full;
    assign cfg_done_o     = done_q;
    assign cfg_error_o    = err_q;
    assign frame_addr_o   = row_q;
    assign frame_data_o   = frame_q;
    assign frame_strobe_o = (state_q == EMIT);

    // FIFO bookkeeping, header parse, frame packing and handshake sequencing
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        frame_d  = frame_q;
        row_d    = row_q;
        count_d  = count_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = err_q;
        pop      = 1'b0;
`ifdef CFG_CRC_EN
        crc_d    = crc_q;
`endif
        // full is judged on the registered level: a same-cycle pop does not make room
        push = self_write_strobe_i && !full;
        if (self_write_strobe_i && full) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head[31:24] == 8'hA5) begin
                        row_d   = head[ROW_ADDR_W-1:0];
                        count_d = head[15:8];
                        idx_d   = '0;
`ifdef CFG_CRC_EN
                        crc_d   = 16'hFFFF;
`endif
                        if (head[15:8] != 8'd0) state_d = LOAD;
                        else                    err_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (!empty) begin
                    pop = 1'b1;
                    frame_d[idx_q*32 +: 32] = head;
`ifdef CFG_CRC_EN
                    crc_d = crc_upd(crc_q, head);
`endif
                    if (idx_q == IW'(WORDS_PER_FRAME - 1)) begin
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (frame_ready_i) begin
                    row_d   = row_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == 8'd1) begin
`ifdef CFG_CRC_EN
                        state_d = CHECK;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef CFG_CRC_EN
            CHECK: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                    if (head[15:0] == crc_q) done_d = 1'b1;
                    else                     err_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = self_write_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
    end

    // State registers; synchronous reset drops any partial frame and FIFO contents
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frame_q  <= '0;
            row_q    <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CFG_CRC_EN
            crc_q    <= 16'hFFFF;
`endif
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frame_q  <= frame_d;
            row_q    <= row_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef CFG_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end
endmodule

// File: tb/tb_efpga_cfg_writer.sv
// Directed bench for efpga_cfg_writer (default 4 words/frame, 5-bit row, depth 4).
// Under CFG_CRC_EN, sequences carry a trailer word and a CRC scenario is added.
module tb_efpga_cfg_writer;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wdata;
    logic         wstb;
    logic         busy, done, err, fstb, frdy;
    logic [4:0]   faddr;
    logic [127:0] fdata;

    int vecs = 0;
    int miss = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    logic [4:0]   last_addr;
    logic [127:0] last_data;
    logic [15:0]  tb_crc;

    efpga_cfg_writer dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .self_write_data_i(wdata), .self_write_strobe_i(wstb),
        .cfg_busy_o(busy), .cfg_done_o(done), .cfg_error_o(err),
        .frame_addr_o(faddr), .frame_data_o(fdata),
        .frame_strobe_o(fstb), .frame_ready_i(frdy)
    );

    always #5 clk = ~clk;

    // transfer/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (fstb && frdy) begin
                xfer_cnt  <= xfer_cnt + 1;
                last_addr <= faddr;
                last_data <= fdata;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] w);
        wstb = 1'b1; wdata = w;
        tick();
        wstb = 1'b0; wdata = '0;
    endtask

    task automatic wr_hdr(input logic [31:0] w);
        tb_crc = 16'hFFFF;
        wr(w);
    endtask

    task automatic wr_dat(input logic [31:0] w);
        tb_crc = ref_crc(tb_crc, w);
        wr(w);
    endtask

    task automatic wr_trl();
`ifdef CFG_CRC_EN
        wr({16'h0, tb_crc});
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; wstb = 1'b0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (done) break;
            tick();
        end
        vecs++;
        if (!done) begin
            miss++;
            $display("FAIL %s: no done pulse within %0d cycles", name, bound);
        end
        tick();
    endtask

    task automatic test_reset();
        frdy = 1'b1;
        do_reset();
        vecs++;
        if ({busy, done, err, fstb, faddr, fdata} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b stb=%b addr=%h data=%h, all 0 required",
                     busy, done, err, fstb, faddr, fdata);
        end
    endtask

    task automatic test_basic();
        int d0;
        do_reset();
        frdy = 1'b1;
        d0 = done_cnt;
        wr_hdr(32'hA500_0103);
        wr_dat(32'h1111_1111); wr_dat(32'h2222_2222);
        wr_dat(32'h3333_3333); wr_dat(32'h4444_4444);
        wr_trl();
`ifdef CFG_CRC_EN
        // trailer write consumed cycle 5, now in cycle 6
`else
        tick();
`endif
        vecs++;
        if (fstb !== 1'b1 || faddr !== 5'd3 || done !== 1'b0) begin
            miss++;
            $display("FAIL basic_strobe_c6: stb=%b addr=%0d done=%b, stb=1 addr=3 done=0 required", fstb, faddr, done);
        end
        vecs++;
        if (fdata !== 128'h44444444_33333333_22222222_11111111) begin
            miss++;
            $display("FAIL basic_data: got %h expected 44444444333333332222222211111111", fdata);
        end
        tick();
`ifdef CFG_CRC_EN
        tick();
`endif
        vecs++;
        if (fstb !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
            miss++;
            $display("FAIL basic_done: stb=%b done=%b err=%b, 0/1/0 required", fstb, done, err);
        end
        tick();
        vecs++;
        if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            miss++;
            $display("FAIL basic_done_single: done=%b pulses=%0d, 0 and 1 required", done, done_cnt - d0);
        end
    endtask

    task automatic test_stall_wrap();
        logic [127:0] f1, f2;
        int x0, d0;
        f1 = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
        f2 = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
        do_reset();
        frdy = 1'b0;
        x0 = xfer_cnt; d0 = done_cnt;
        wr_hdr(32'hA500_021F);
        wr_dat(32'hA1A1A1A1); wr_dat(32'hA2A2A2A2); wr_dat(32'hA3A3A3A3); wr_dat(32'hA4A4A4A4);
        // frame 1 is on the port from cycle 6; frame 2 words fill the FIFO meanwhile
        wr_dat(32'hB1B1B1B1);
        vecs++;
        if (fstb !== 1'b1 || faddr !== 5'd31 || fdata !== f1) begin
            miss++;
            $display("FAIL stall_c6: stb=%b addr=%0d data=%h, 1/31/%h required", fstb, faddr, fdata, f1);
        end
        wr_dat(32'hB2B2B2B2); wr_dat(32'hB3B3B3B3); wr_dat(32'hB4B4B4B4);
        vecs++;
        if (busy !== 1'b1) begin
            miss++;
            $display("FAIL stall_busy_full: busy=%b, 1 required", busy);
        end
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (fstb !== 1'b1 || faddr !== 5'd31 || fdata !== f1) begin
                miss++;
                $display("FAIL stall_hold[%0d]: stb=%b addr=%0d data=%h", i, fstb, faddr, fdata);
            end
            tick();
        end
        frdy = 1'b1;
        tick(); tick();
        wr_trl();
        wait_done("stall_wrap", 40);
        vecs++;
        if (xfer_cnt - x0 !== 2 || last_addr !== 5'd0 || last_data !== f2) begin
            miss++;
            $display("FAIL stall_wrap_frame2: xfers=%0d addr=%0d data=%h, 2/0/%h required",
                     xfer_cnt - x0, last_addr, last_data, f2);
        end
        vecs++;
        if (done_cnt - d0 !== 1 || err !== 1'b0) begin
            miss++;
            $display("FAIL stall_wrap_done: pulses=%0d err=%b, 1 and 0 required", done_cnt - d0, err);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        frdy = 1'b0;
        wr_hdr(32'hA500_0200);
        for (int i = 1; i <= 8; i++) wr_dat({4{i[7:0]}});
        vecs++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miss++;
            $display("FAIL ovf_full: busy=%b err=%b, 1 and 0 required", busy, err);
        end
        wr(32'h0909_0909);
        vecs++;
        if (err !== 1'b1) begin
            miss++;
            $display("FAIL ovf_error: err=%b, 1 required", err);
        end
        frdy = 1'b1;
        tick(); tick();
        wr_trl();
        wait_done("overflow", 40);
        vecs++;
        if (last_data !== 128'h08080808_07070707_06060606_05050505 || last_addr !== 5'd1) begin
            miss++;
            $display("FAIL ovf_frame2: addr=%0d data=%h, 1/08080808070707070606060605050505 required",
                     last_addr, last_data);
        end
        vecs++;
        if (err !== 1'b1) begin
            miss++;
            $display("FAIL ovf_sticky: err=%b, 1 required", err);
        end
    endtask

    task automatic test_bad_header();
        int x0;
        do_reset();
        frdy = 1'b1;
        x0 = xfer_cnt;
        wr(32'h1234_5678);
        tick();
        vecs++;
        if (err !== 1'b1) begin
            miss++;
            $display("FAIL badhdr_err: err=%b, 1 required", err);
        end
        wr_hdr(32'hA500_0000);
        for (int i = 0; i < 6; i++) tick();
        vecs++;
        if (fstb !== 1'b0 || xfer_cnt !== x0) begin
            miss++;
            $display("FAIL badhdr_nostrobe: stb=%b xfers=%0d, 0 and 0 required", fstb, xfer_cnt - x0);
        end
        wr_hdr(32'hA500_0107);
        wr_dat(32'hC0C0C0C0); wr_dat(32'hC1C1C1C1); wr_dat(32'hC2C2C2C2); wr_dat(32'hC3C3C3C3);
        wr_trl();
        wait_done("badhdr_recover", 20);
        vecs++;
        if (last_addr !== 5'd7 || last_data !== 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0 || err !== 1'b1) begin
            miss++;
            $display("FAIL badhdr_recover: addr=%0d data=%h err=%b", last_addr, last_data, err);
        end
    endtask

    task automatic test_reset_mid();
        int x0, d0;
        do_reset();
        frdy = 1'b1;
        x0 = xfer_cnt; d0 = done_cnt;
        wr_hdr(32'hA500_0102);
        wr_dat(32'hD1D1D1D1); wr_dat(32'hD2D2D2D2);
        tick();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        vecs++;
        if ({busy, done, err, fstb, faddr, fdata} !== '0 || xfer_cnt !== x0 || done_cnt !== d0) begin
            miss++;
            $display("FAIL reset_mid: stb=%b done=%b err=%b addr=%0d data=%h xfers=%0d dones=%0d",
                     fstb, done, err, faddr, fdata, xfer_cnt - x0, done_cnt - d0);
        end
        wr_hdr(32'hA500_0102);
        wr_dat(32'hE0E0E0E0); wr_dat(32'hE1E1E1E1); wr_dat(32'hE2E2E2E2); wr_dat(32'hE3E3E3E3);
        wr_trl();
        wait_done("reset_mid_rerun", 20);
        vecs++;
        if (last_addr !== 5'd2 || last_data !== 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0 || err !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid_rerun: addr=%0d data=%h err=%b", last_addr, last_data, err);
        end
    endtask

`ifdef CFG_CRC_EN
    task automatic test_crc();
        int d0, x0;
        do_reset();
        frdy = 1'b1;
        wr_hdr(32'hA500_0104);
        wr_dat(32'h0123_4567); wr_dat(32'h89AB_CDEF); wr_dat(32'hDEAD_BEEF); wr_dat(32'h0000_0001);
        wr_trl();
        wait_done("crc_good", 20);
        vecs++;
        if (err !== 1'b0) begin
            miss++;
            $display("FAIL crc_good_err: err=%b, 0 required", err);
        end
        d0 = done_cnt; x0 = xfer_cnt;
        wr_hdr(32'hA500_0105);
        wr_dat(32'h0123_4567); wr_dat(32'h89AB_CDEF); wr_dat(32'hDEAD_BEEF); wr_dat(32'h0000_0001);
        wr({16'h0, tb_crc ^ 16'h0001});
        for (int i = 0; i < 10; i++) tick();
        vecs++;
        if (err !== 1'b1 || done_cnt !== d0 || xfer_cnt - x0 !== 1) begin
            miss++;
            $display("FAIL crc_bad: err=%b dones=%0d xfers=%0d, 1/0/1 required", err, done_cnt - d0, xfer_cnt - x0);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; wstb = 1'b0; wdata = '0; frdy = 1'b0; tb_crc = 16'hFFFF;
        test_reset();
        test_basic();
        test_stall_wrap();
        test_overflow();
        test_bad_header();
        test_reset_mid();
`ifdef CFG_CRC_EN
        test_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
